mem_stage_ctrl: RTL and testbench
=================================

# mem_stage_ctrl

Memory-stage controller sitting on the consumer side of the EX/MEM pipeline register. It takes the latched EX/MEM fields and, for loads and stores, runs a request/acknowledge transaction to data memory while stalling the upstream pipeline. It then registers the result into the MEM/WB fields for write-back. Non-memory instructions pass through with one cycle of latency.

## Interface
Parameters:
- DATA_W, 64, datapath width
- ADDR_W, 8, data-memory word address width, taken from in_Z[ADDR_W-1:0]
- TIMEOUT, 16, maximum BUSY cycles waiting for dmem_ack (≥1)

Ports:
- clk  in  1  clock (reset reset, asynchronous, active-low; clock clk)
- reset  in  1  asynchronous active-low reset
- in_valid  in  1  EX/MEM slot holds a live instruction
- in_WRegEn  in  1  instruction writes a register
- in_WMemEn  in  1  store
- in_RMemEn  in  1  load
- in_R1out  in  DATA_W  operand 1; unused except for debug
- in_R2out  in  DATA_W  store data
- in_WReg1  in  5  destination register
- in_Z  in  DATA_W  ALU result / memory address
- stall  out  1  upstream must hold EX/MEM contents this cycle (combinational)
- dmem_req  out  1  memory request (registered)
- dmem_we  out  1  1 = write, 0 = read
- dmem_addr  out  ADDR_W  word address
- dmem_wdata  out  DATA_W  write data
- dmem_ack  in  1  memory completes the request this cycle
- dmem_rdata  in  DATA_W  read data, valid when dmem_ack=1 and dmem_we=0
- WB_valid  out  1  MEM/WB slot holds a completed instruction
- WB_WRegEn  out  1  write-back enable
- WB_WReg1  out  5  write-back register
- WB_WData  out  DATA_W  write-back data
- err  out  1  sticky timeout flag

## Operation
- Memory op: in_valid & (in_WMemEn | in_RMemEn). If both enables are set, the instruction is a store and in_RMemEn is ignored.
- FSM states: IDLE and BUSY.
- IDLE, memory op present:
  - Latch addr = in_Z[ADDR_W-1:0], wdata = in_R2out, we = in_WMemEn.
  - Clear the timeout counter and go to BUSY.
  - WB_valid ← 0.
- IDLE, non-memory op with in_valid=1:
  - WB_valid ← 1, WB_WRegEn ← in_WRegEn, WB_WReg1 ← in_WReg1, WB_WData ← in_Z.
- IDLE, in_valid=0: WB_valid ← 0, WB_WRegEn ← 0. WB_WReg1 and WB_WData hold.
- BUSY: dmem_req=1. dmem_we, dmem_addr and dmem_wdata hold their latched values.
- BUSY with dmem_ack=1:
  - Go to IDLE.
  - WB_valid ← 1, WB_WRegEn ← in_WRegEn, WB_WReg1 ← in_WReg1.
  - WB_WData ← dmem_rdata for a load, in_Z for a store.
- BUSY with dmem_ack=0: increment the counter. When the counter reaches TIMEOUT-1 without an ack:
  - err ← 1 (sticky).
  - Go to IDLE.
  - Retire the instruction: WB_valid ← 1, WB_WRegEn ← 0.
- stall = (IDLE & memory op) | (BUSY & !dmem_ack & !timeout_hit).
- Upstream holds in_* stable while stall=1. The block relies on this.
- dmem_ack outside BUSY is ignored.

## Timing
- Reset values: state IDLE; dmem_req, dmem_we, dmem_addr, dmem_wdata all 0; WB_valid, WB_WRegEn, WB_WReg1, WB_WData all 0; err 0; counter 0.
- Non-memory latency: the WB outputs update at the first clk edge after the instruction is presented. stall stays 0.
- Memory latency: 1 launch cycle + N BUSY cycles, where N ≥ 1 is the cycle on which ack arrives.
  - The WB outputs update at the edge that ends the ack cycle.
  - stall is 1 for exactly N cycles, so zero-wait memory gives a 1-cycle stall.
- Back-to-back memory ops: the next op is launched in the IDLE cycle immediately after the ack. There is no bubble beyond the launch cycle.
- Reset asserted mid-BUSY: dmem_req drops asynchronously, the transaction is abandoned, and no WB_valid is produced.
- The counter width must hold TIMEOUT-1 and must not wrap.

## Test plan
- ALU pass-through:
  - Stimulus: in_valid=1, in_WRegEn=1, in_WReg1=5, in_Z=0x1234.
  - Required: at the next edge WB_valid=1, WB_WReg1=5, WB_WData=0x1234. stall never asserts.
- Store, zero wait:
  - Stimulus: in_WMemEn=1, in_Z=0x2A, in_R2out=0xDEAD, with dmem_ack=1 on the first req cycle.
  - Required: dmem_req=1, dmem_we=1, dmem_addr=0x2A, dmem_wdata=0xDEAD. stall is 1 for 1 cycle. WB_valid=1 and WB_WRegEn=0 next.
- Load, 3 wait states:
  - Stimulus: in_RMemEn=1, in_WRegEn=1, in_WReg1=9, in_Z=0x10. Ack arrives on the 4th BUSY cycle with rdata=0xBEEF.
  - Required: stall is high for 4 cycles, then WB_WData=0xBEEF and WB_WReg1=9.
- Timeout:
  - Stimulus: TIMEOUT=4, load, dmem_ack held at 0.
  - Required: after 4 BUSY cycles err=1, state is IDLE, WB_valid=1, WB_WRegEn=0. err stays 1 until reset.
- Reset mid-transaction:
  - Stimulus: assert reset during the 2nd BUSY cycle.
  - Required: dmem_req, WB_valid and stall go to 0 immediately. After release, a new ALU op completes normally.
- Back-to-back ops:
  - Stimulus: a store, then a load, then an ALU op, with zero-wait memory.
  - Required: WB_valid pulses in order with correct data. Total 5 cycles from the first launch to the ALU op's WB.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl
//   Memory-stage controller on the consumer side of the EX/MEM register.
//   Loads and stores run a req/ack transaction to data memory while the
//   upstream pipeline is stalled. Everything else retires into the MEM/WB
//   fields with one cycle of latency.
//
// Ports
//   clk, reset           clock, asynchronous active-low reset
//   in_*                 latched EX/MEM fields (held stable while stall=1)
//   stall                combinational hold request to upstream
//   dmem_req/we/addr/    registered memory request; addr/wdata/we stay
//   dmem_wdata           latched for the whole transaction
//   dmem_ack/rdata       memory completion and read data
//   WB_*                 registered MEM/WB fields
//   err                  sticky flag, set when memory never acks
module mem_stage_ctrl #(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_WRegEn,
    input  logic              in_WMemEn,
    input  logic              in_RMemEn,
    input  logic [DATA_W-1:0] in_R1out,
    input  logic [DATA_W-1:0] in_R2out,
    input  logic [4:0]        in_WReg1,
    input  logic [DATA_W-1:0] in_Z,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              WB_valid,
    output logic              WB_WRegEn,
    output logic [4:0]        WB_WReg1,
    output logic [DATA_W-1:0] WB_WData,
    output logic              err
);

    // Counter only has to reach TIMEOUT-1; it stops there, so it never wraps.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               req_q, req_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               wb_valid_q, wb_valid_d;
    logic               wb_wregen_q, wb_wregen_d;
    logic [4:0]         wb_wreg1_q, wb_wreg1_d;
    logic [DATA_W-1:0]  wb_wdata_q, wb_wdata_d;
    logic               err_q, err_d;

    logic mem_op;
    logic busy;
    logic timeout_hit;
    logic unused_r1;

    // Operand 1 is carried for debug visibility only.
    assign unused_r1 = ^in_R1out;

    assign mem_op      = in_valid & (in_WMemEn | in_RMemEn);
    assign busy        = (state_q == BUSY);
    assign timeout_hit = busy & ~dmem_ack & (cnt_q == CNT_W'(TIMEOUT - 1));

    // Gated by reset so the hold request drops the moment reset asserts,
    // even with a memory op still sitting in EX/MEM.
    assign stall = reset & (((state_q == IDLE) & mem_op) |
                            (busy & ~dmem_ack & ~timeout_hit));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wb_valid_d  = wb_valid_q;
        wb_wregen_d = wb_wregen_q;
        wb_wreg1_d  = wb_wreg1_q;
        wb_wdata_d  = wb_wdata_q;
        err_d       = err_q;

        if (state_q == IDLE) begin
            if (mem_op) begin
                // Store wins when both enables are set.
                addr_d      = in_Z[ADDR_W-1:0];
                wdata_d     = in_R2out;
                we_d        = in_WMemEn;
                cnt_d       = '0;
                req_d       = 1'b1;
                state_d     = BUSY;
                wb_valid_d  = 1'b0;
                // An empty MEM/WB slot must not carry a live write enable.
                wb_wregen_d = 1'b0;
            end else if (in_valid) begin
                wb_valid_d  = 1'b1;
                wb_wregen_d = in_WRegEn;
                wb_wreg1_d  = in_WReg1;
                wb_wdata_d  = in_Z;
            end else begin
                wb_valid_d  = 1'b0;
                wb_wregen_d = 1'b0;
            end
        end else begin
            if (dmem_ack) begin
                state_d     = IDLE;
                req_d       = 1'b0;
                wb_valid_d  = 1'b1;
                wb_wregen_d = in_WRegEn;
                wb_wreg1_d  = in_WReg1;
                wb_wdata_d  = we_q ? in_Z : dmem_rdata;
            end else if (timeout_hit) begin
                // Retire as a no-op so the pipeline keeps moving.
                err_d       = 1'b1;
                state_d     = IDLE;
                req_d       = 1'b0;
                wb_valid_d  = 1'b1;
                wb_wregen_d = 1'b0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wb_valid_q  <= 1'b0;
            wb_wregen_q <= 1'b0;
            wb_wreg1_q  <= '0;
            wb_wdata_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wb_valid_q  <= wb_valid_d;
            wb_wregen_q <= wb_wregen_d;
            wb_wreg1_q  <= wb_wreg1_d;
            wb_wdata_q  <= wb_wdata_d;
            err_q       <= err_d;
        end
    end

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign WB_valid   = wb_valid_q;
    assign WB_WRegEn  = wb_wregen_q;
    assign WB_WReg1   = wb_wreg1_q;
    assign WB_WData   = wb_wdata_q;
    assign err        = err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: each issued instruction pushes its
// expected MEM/WB record; a monitor pops one record per WB_valid cycle.
module tb_mem_stage_ctrl;

    localparam int DATA_W  = 64;
    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 4;

    typedef struct packed {
        logic        wen;
        logic [4:0]  rd;
        logic [63:0] data;
    } sb_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0, in_WRegEn = 1'b0, in_WMemEn = 1'b0, in_RMemEn = 1'b0;
    logic [DATA_W-1:0] in_R1out = '0, in_R2out = '0, in_Z = '0;
    logic [4:0]        in_WReg1 = '0;
    logic              stall, dmem_req, dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ack = 1'b0;
    logic [DATA_W-1:0] dmem_rdata = '0;
    logic              WB_valid, WB_WRegEn, err;
    logic [4:0]        WB_WReg1;
    logic [DATA_W-1:0] WB_WData;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    sb_t         sbq[$];
    logic [4:0]  m_reg  = '0;
    logic [63:0] m_data = '0;

    mem_stage_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_WRegEn(in_WRegEn), .in_WMemEn(in_WMemEn),
        .in_RMemEn(in_RMemEn), .in_R1out(in_R1out), .in_R2out(in_R2out),
        .in_WReg1(in_WReg1), .in_Z(in_Z), .stall(stall),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .WB_valid(WB_valid), .WB_WRegEn(WB_WRegEn), .WB_WReg1(WB_WReg1),
        .WB_WData(WB_WData), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One retirement per cycle with WB_valid high.
    always @(posedge clk) begin
        sb_t e;
        #1;
        if (reset && WB_valid) begin
            if (sbq.size() == 0) begin
                chk("wb_unexpected", WB_valid, 1'b0);
            end else begin
                e = sbq.pop_front();
                chk("wb_wen",  WB_WRegEn, e.wen);
                chk("wb_reg",  WB_WReg1,  e.rd);
                chk("wb_data", WB_WData,  e.data);
            end
        end
    end

    task automatic idle();
        @(negedge clk);
        in_valid = 0; in_WMemEn = 0; in_RMemEn = 0; in_WRegEn = 0;
        #1 chk("idle_stall", stall, 1'b0);
        @(posedge clk); #1;
        chk("idle_vld", WB_valid, 1'b0);
    endtask

    // waits < 0: memory never acks (timeout path).
    task automatic op(input logic wm, input logic rm, input logic wen, input logic [4:0] rd,
                      input logic [63:0] z, input logic [63:0] r2, input int waits,
                      input logic [63:0] rdat);
        sb_t e;
        int  stalls;
        bit  to;
        bit  done;
        @(negedge clk);
        in_valid = 1; in_WMemEn = wm; in_RMemEn = rm; in_WRegEn = wen;
        in_WReg1 = rd; in_Z = z; in_R2out = r2; in_R1out = {$urandom, $urandom};
        to = (waits < 0);
        if (!(wm | rm)) begin
            e = '{wen, rd, z};
            sbq.push_back(e); m_reg = rd; m_data = z;
            #1 chk("alu_stall", stall, 1'b0);
            @(posedge clk); #1;
            return;
        end
        if (to) begin
            e = '{1'b0, m_reg, m_data};
        end else begin
            e = '{wen, rd, (wm ? z : rdat)};
            m_reg = rd; m_data = e.data;
        end
        sbq.push_back(e);
        #1 stalls = int'(stall);
        done = 0;
        for (int k = 0; k < TIMEOUT && !done; k++) begin
            @(negedge clk);
            chk("req",   dmem_req,   1'b1);
            chk("we",    dmem_we,    wm);
            chk("addr",  dmem_addr,  z[7:0]);
            chk("wdata", dmem_wdata, r2);
            if (!to && k == waits) begin
                dmem_ack = 1; dmem_rdata = rdat;
            end
            #1 if (stall) stalls++;
            if ((!to && k == waits) || (to && k == TIMEOUT - 1)) done = 1;
        end
        @(posedge clk); #1;
        dmem_ack = 0;
        chk("stall_cycles", stalls, to ? TIMEOUT : waits + 1);
        chk("req_done", dmem_req, 1'b0);
        if (to) chk("err_set", err, 1'b1);
    endtask

    initial begin
        int t0;
        #12;
        chk("rst_req",   dmem_req,   1'b0);
        chk("rst_we",    dmem_we,    1'b0);
        chk("rst_addr",  dmem_addr,  '0);
        chk("rst_wdata", dmem_wdata, '0);
        chk("rst_vld",   WB_valid,   1'b0);
        chk("rst_wen",   WB_WRegEn,  1'b0);
        chk("rst_reg",   WB_WReg1,   '0);
        chk("rst_data",  WB_WData,   '0);
        chk("rst_err",   err,        1'b0);
        chk("rst_stall", stall,      1'b0);
        @(negedge clk) reset = 1;
        idle();

        op(0, 0, 1, 5'd5, 64'h1234, 64'h0, 0, 64'h0);          // ALU pass-through
        op(1, 0, 0, 5'd0, 64'h2A, 64'hDEAD, 0, 64'h5555);       // store, zero wait
        op(0, 1, 1, 5'd9, 64'h10, 64'h0, 3, 64'hBEEF);          // load, 3 wait states
        idle();
        op(1, 1, 1, 5'd6, 64'h3C, 64'hCAFE, 1, 64'h7777);       // both enables -> store
        op(0, 1, 1, 5'd12, 64'h33, 64'h0, -1, 64'h0);           // timeout
        idle();
        chk("err_sticky0", err, 1'b1);
        op(0, 0, 1, 5'd7, 64'h77, 64'h0, 0, 64'h0);
        chk("err_sticky1", err, 1'b1);

        // Reset during the 2nd BUSY cycle of a load.
        @(negedge clk);
        in_valid = 1; in_RMemEn = 1; in_WMemEn = 0; in_WRegEn = 1; in_WReg1 = 5'd8; in_Z = 64'h55;
        @(negedge clk);
        chk("rstmid_req_pre", dmem_req, 1'b1);
        @(negedge clk);
        #2 reset = 0;
        #1;
        chk("rstmid_req",   dmem_req, 1'b0);
        chk("rstmid_vld",   WB_valid, 1'b0);
        chk("rstmid_stall", stall,    1'b0);
        chk("rstmid_err",   err,      1'b0);
        @(negedge clk);
        in_valid = 0; in_RMemEn = 0; in_WRegEn = 0;
        m_reg = '0; m_data = '0;
        reset = 1;
        op(0, 0, 1, 5'd3, 64'hABC, 64'h0, 0, 64'h0);

        // Back-to-back: store, load, ALU with zero-wait memory.
        t0 = cyc;
        op(1, 0, 0, 5'd0, 64'h40, 64'h1111, 0, 64'h9999);
        op(0, 1, 1, 5'd2, 64'h41, 64'h0, 0, 64'h2222);
        op(0, 0, 1, 5'd4, 64'h99, 64'h0, 0, 64'h0);
        chk("b2b_cycles", cyc - t0, 5);
        idle();
        idle();
        chk("sb_empty", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
